// File: rtl/audio_adc_deserializer.sv
// ---------------------------------------------------------------------------
// audio_adc_deserializer
//
// Purpose:
//   Captures stereo I2S audio from a codec that drives its own bit clock and
//   LR clock. The codec signals are brought into the clk domain, one I2S frame
//   at a time is decoded into left/right words, and complete stereo pairs are
//   buffered in a small FIFO for a downstream consumer.
//
// Ports:
//   clk, reset_n        system clock (only clock) and async active-low reset
//   enable              capture enable; low discards any partial frame
//   aud_bclk            codec bit clock (asynchronous to clk)
//   aud_adclrck         codec LR clock, low = left, high = right
//   aud_adcdat          codec serial data, I2S, MSB first
//   sample_left/right   pair at the FIFO head (zero while the FIFO is empty)
//   sample_valid        FIFO non-empty
//   sample_ready        consumer accepts the head pair
//   fifo_level          number of pairs stored, 0..FIFO_DEPTH
//   overflow            sticky flag: a complete pair was dropped (FIFO full)
//   overflow_clr        clears overflow (a simultaneous new drop wins)
//   dbg_state           current capture FSM state
//
// Handshake: a pair leaves the FIFO on every clk edge where sample_valid and
// sample_ready are both high; the head may change only after such a pop.
// ---------------------------------------------------------------------------
module audio_adc_deserializer #(
    parameter int DATA_WIDTH = 24,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic                          aud_bclk,
    input  logic                          aud_adclrck,
    input  logic                          aud_adcdat,
    output logic [DATA_WIDTH-1:0]         sample_left,
    output logic [DATA_WIDTH-1:0]         sample_right,
    output logic                          sample_valid,
    input  logic                          sample_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    input  logic                          overflow_clr,
    output logic [1:0]                    dbg_state
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam int PAIR_W = 2 * DATA_WIDTH;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SYNC  = 2'd1;
    localparam logic [1:0] ST_LEFT  = 2'd2;
    localparam logic [1:0] ST_RIGHT = 2'd3;

    // Synchronizers: bit 2 = bclk, bit 1 = lrck, bit 0 = dat.
    logic [2:0] sync1_d, sync1_q, sync2_d, sync2_q;
    logic       bclk_prev_d, bclk_prev_q;

    logic                  bit_event, lrck_s, dat_s, lrck_change;
    logic [DATA_WIDTH-1:0] shifted;

    logic [1:0]            state_d, state_q;
    logic [CNT_W-1:0]      bit_cnt_d, bit_cnt_q;
    logic [DATA_WIDTH-1:0] shift_d, shift_q;
    logic [DATA_WIDTH-1:0] left_word_d, left_word_q;
    logic                  left_valid_d, left_valid_q;
    logic                  lrck_prev_d, lrck_prev_q;
    logic                  push_req_d, push_req_q;
    logic [DATA_WIDTH-1:0] push_left_d, push_left_q;
    logic [DATA_WIDTH-1:0] push_right_d, push_right_q;

    logic [PAIR_W-1:0]     mem_d [FIFO_DEPTH];
    logic [PAIR_W-1:0]     mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q;
    logic [LVL_W-1:0]      level_d, level_q;
    logic                  overflow_d, overflow_q;
    logic                  fifo_full, do_pop, do_push, ovf_set;
    logic [PAIR_W-1:0]     head;

    // ---------------------------------------------------------------- sync
    always_comb begin
        sync1_d     = {aud_bclk, aud_adclrck, aud_adcdat};
        sync2_d     = sync1_q;
        bclk_prev_d = sync2_q[2];
    end

    // lrck and dat travel through identical synchronizer stages as bclk, so
    // on a bit event they are the values the codec held at that BCLK edge.
    assign bit_event   = sync2_q[2] & ~bclk_prev_q;
    assign lrck_s      = sync2_q[1];
    assign dat_s       = sync2_q[0];
    assign lrck_change = (lrck_s != lrck_prev_q);
    assign shifted     = {shift_q[DATA_WIDTH-2:0], dat_s};

    // ------------------------------------------------------------ capture
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        left_word_d  = left_word_q;
        left_valid_d = left_valid_q;
        lrck_prev_d  = lrck_prev_q;
        push_req_d   = 1'b0;
        push_left_d  = push_left_q;
        push_right_d = push_right_q;

        // Tracked on every bit event so SYNC sees a genuine 1->0 edge.
        if (bit_event) begin
            lrck_prev_d = lrck_s;
        end

        if (!enable) begin
            state_d      = ST_IDLE;
            bit_cnt_d    = '0;
            left_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d      = ST_SYNC;
                    bit_cnt_d    = '0;
                    left_valid_d = 1'b0;
                end
                ST_SYNC: begin
                    if (bit_event && lrck_prev_q && !lrck_s) begin
                        state_d      = ST_LEFT;
                        bit_cnt_d    = '0;
                        left_valid_d = 1'b0;
                    end
                end
                default: begin
                    if (bit_event) begin
                        if (lrck_change) begin
                            // This bit is the I2S delay slot and carries no data.
                            bit_cnt_d = '0;
                            state_d   = lrck_s ? ST_RIGHT : ST_LEFT;
                            // A new frame begins: no left word belongs to it yet.
                            if (!lrck_s) begin
                                left_valid_d = 1'b0;
                            end
                        end else if (bit_cnt_q < CNT_W'(DATA_WIDTH)) begin
                            shift_d   = shifted;
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                            if (bit_cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                                if (state_q == ST_LEFT) begin
                                    left_word_d  = shifted;
                                    left_valid_d = 1'b1;
                                end else if (left_valid_q) begin
                                    push_req_d   = 1'b1;
                                    push_left_d  = left_word_q;
                                    push_right_d = shifted;
                                    left_valid_d = 1'b0;
                                end
                            end
                        end
                    end
                end
            endcase
        end
    end

    // --------------------------------------------------------------- fifo
    assign fifo_full    = (level_q == LVL_W'(FIFO_DEPTH));
    assign sample_valid = (level_q != '0);
    assign do_pop       = sample_valid & sample_ready;
    // When full, a simultaneous pop frees the slot the push writes into.
    assign do_push      = push_req_q & (~fifo_full | do_pop);
    assign ovf_set      = push_req_q & fifo_full & ~do_pop;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;

        if (do_push) begin
            mem_d[wr_ptr_q] = {push_left_q, push_right_q};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (do_push && !do_pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (!do_push && do_pop) begin
            level_d = level_q - LVL_W'(1);
        end

        if (ovf_set) begin
            overflow_d = 1'b1;
        end else if (overflow_clr) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    assign head         = mem_q[rd_ptr_q];
    assign sample_left  = sample_valid ? head[PAIR_W-1:DATA_WIDTH] : '0;
    assign sample_right = sample_valid ? head[DATA_WIDTH-1:0] : '0;
    assign fifo_level   = level_q;
    assign overflow     = overflow_q;
    assign dbg_state    = state_q;

    // ---------------------------------------------------------- registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            bclk_prev_q  <= 1'b0;
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            left_word_q  <= '0;
            left_valid_q <= 1'b0;
            lrck_prev_q  <= 1'b0;
            push_req_q   <= 1'b0;
            push_left_q  <= '0;
            push_right_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            overflow_q   <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            bclk_prev_q  <= bclk_prev_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            left_word_q  <= left_word_d;
            left_valid_q <= left_valid_d;
            lrck_prev_q  <= lrck_prev_d;
            push_req_q   <= push_req_d;
            push_left_q  <= push_left_d;
            push_right_q <= push_right_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            overflow_q   <= overflow_d;
        end
    end

endmodule

// File: doc/audio_adc_deserializer.md
AUDIO_ADC_DESERIALIZER -- requirements
Module: audio_adc_deserializer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 24: bits per channel word captured from the codec.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8 (power of two): number of stereo pairs buffered.
REQ-003 SHALL have port clk, input, 1: system clock (50 MHz), the only clock.
REQ-004 SHALL have port reset_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port enable, input, 1: capture enable.
REQ-006 SHALL have port aud_bclk, input, 1: codec bit clock (codec master), asynchronous to clk.
REQ-007 SHALL have port aud_adclrck, input, 1: codec ADC LR clock; low = left, high = right.
REQ-008 SHALL have port aud_adcdat, input, 1: codec ADC serial data, I2S, MSB first.
REQ-009 SHALL have port sample_left, output, DATA_WIDTH: left word at FIFO head.
REQ-010 SHALL have port sample_right, output, DATA_WIDTH: right word at FIFO head.
REQ-011 SHALL have port sample_valid, output, 1: FIFO non-empty.
REQ-012 SHALL have port sample_ready, input, 1: consumer accepts head pair.
REQ-013 SHALL have port fifo_level, output, clog2(FIFO_DEPTH)+1: pairs stored.
REQ-014 SHALL have port overflow, output, 1: sticky pair-dropped flag.
REQ-015 SHALL have port overflow_clr, input, 1: clears overflow.

Function
REQ-016 SHALL pass aud_bclk, aud_adclrck and aud_adcdat through 2-flop synchronizers; a bit event is a 0->1 transition of synchronized bclk.
REQ-017 SHALL sample synchronized lrck and dat together on each bit event; no other cycle samples them.
REQ-018 SHALL implement states IDLE, SYNC, LEFT and RIGHT.
- IDLE: enable=0.
- IDLE->SYNC: enable=1.
- Any state->IDLE: enable=0; the partial word is discarded.
REQ-019 In SYNC, SHALL ignore data until a bit event sees lrck 1->0, then enter LEFT.
REQ-020 On each lrck change at a bit event, SHALL:
- zero the bit counter;
- discard that bit as the I2S one-BCLK delay slot;
- switch to LEFT (1->0) or RIGHT (0->1).
REQ-021 Subsequent bit events SHALL shift dat into the word LSB-ward while bit counter < DATA_WIDTH; bits beyond DATA_WIDTH SHALL be ignored.
REQ-022 A completed left word SHALL be held. A completed right word SHALL be pushed with the held left word as one pair, only if a left word completed earlier in the same frame.
REQ-023 If lrck changes before a word completes, that word SHALL be discarded and no push SHALL occur for that frame.
REQ-024 Words SHALL be stored unmodified, two's complement.
REQ-025 The push SHALL occur on the clk cycle after the bit event completing the right word. sample_valid SHALL rise on the following cycle when the FIFO was empty (2 clk after the completing bit event).
REQ-026 Pop SHALL occur on a cycle with sample_valid=1 and sample_ready=1. sample_left/right SHALL show the next pair on the cycle after the pop.
REQ-027 Push into a full FIFO with no pop SHALL drop the new pair, set overflow, and leave contents unchanged.
REQ-028 Push and pop in the same cycle SHALL both take effect, including when full; fifo_level SHALL be unchanged.
REQ-029 overflow_clr SHALL clear overflow. If a set and overflow_clr occur in the same cycle, set SHALL win.
REQ-030 Pointers SHALL wrap modulo FIFO_DEPTH. fifo_level SHALL range 0..FIFO_DEPTH.
REQ-031 With enable=0, FIFO contents SHALL be retained and SHALL remain poppable.

Reset
REQ-032 reset_n=0 SHALL asynchronously force:
- state IDLE;
- bit counter 0 and held left word invalid;
- FIFO empty, sample_valid=0, fifo_level=0, overflow=0;
- sample_left=0, sample_right=0;
- synchronizer flops 0.
REQ-033 Reset asserted mid-frame SHALL discard all partial and buffered data. After release, capture SHALL resume only via SYNC.

Verification
REQ-034 Enable=1, BCLK 3.072 MHz, frame L=0x123456, R=0xFEDCBA, ready=1 -> one pair L=0x123456, R=0xFEDCBA; sample_valid high 1 clk; 2 clk latency after the last right bit.
REQ-035 Start mid-right-channel, then two full frames -> exactly 2 pairs; no partial pair emitted.
REQ-036 ready=0, 10 frames -> fifo_level=8, overflow=1, head = frame 1. Pulse overflow_clr -> overflow=0.
REQ-037 FIFO full, ready=1 on the push cycle -> level stays 8, overflow stays 0, the new pair lands at the tail.
REQ-038 Drop enable mid-left-word, re-enable -> partial word discarded; next output = the next complete frame.
REQ-039 Assert reset_n mid-frame with 3 pairs queued -> sample_valid=0 and level=0 immediately, without a clock edge.
